// File: rtl/z_pkg.sv
// Shared encodings for the one-hot walk detector: FSM states and the 4-sample pattern.
package z_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2,
    GOT4 = 2'd3
  } state_e;

  localparam logic [3:0] PAT0 = 4'h1;
  localparam logic [3:0] PAT1 = 4'h2;
  localparam logic [3:0] PAT2 = 4'h4;
  localparam logic [3:0] PAT3 = 4'h8;

  // A PAT0 sample always restarts the walk, whatever state it arrives in.
  function automatic state_e next_state(input state_e s, input logic [3:0] z);
    state_e n;
    n = IDLE;
    if (z == PAT0) begin
      n = GOT1;
    end else begin
      case (s)
        GOT1:    n = (z == PAT1) ? GOT2 : IDLE;
        GOT2:    n = (z == PAT2) ? GOT4 : IDLE;
        default: n = IDLE;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; updates one cycle after inc/clr.
// Clear has priority over increment; holding at all-ones absorbs further increments.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/z_sequence_detector.sv
// Detects consumed Z samples 1,2,4,8; match and count appear one clock after the final sample.
// No backpressure: every edge with z_valid=1 consumes z_in; clear discards the sample at its edge.
module z_sequence_detector
  import z_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         z_in,
  input  logic               z_valid,
  input  logic               clear,
  output logic               match,
  output logic [COUNT_W-1:0] match_count,
  output logic [3:0]         last_z,
  output logic [1:0]         state
);

  state_e     state_q, state_d;
  logic       match_q, match_d;
  logic [3:0] last_z_q, last_z_d;
  logic       take;
  logic       done;

  assign take = z_valid && !clear;
  assign done = take && (state_q == GOT4) && (z_in == PAT3);

  always_comb begin
    state_d  = state_q;
    match_d  = 1'b0;
    last_z_d = last_z_q;
    if (clear) begin
      state_d  = IDLE;
      last_z_d = 4'h0;
    end else if (z_valid) begin
      state_d  = next_state(state_q, z_in);
      match_d  = done;
      last_z_d = z_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      match_q  <= 1'b0;
      last_z_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      last_z_q <= last_z_d;
    end
  end

  sat_counter #(
    .W(COUNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (done),
    .clr  (clear),
    .count(match_count)
  );

  assign match  = match_q;
  assign last_z = last_z_q;
  assign state  = state_q;

endmodule

// File: tb/tb_z_sequence_detector.sv
// Scoreboarded bench: a sample-history model predicts each edge's outputs into a queue.
module tb_z_sequence_detector;

  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [3:0]    z_in;
  logic          z_valid;
  logic          clear;
  logic          match;
  logic [CW-1:0] match_count;
  logic [3:0]    last_z;
  logic [1:0]    state;

  typedef struct packed {
    logic [1:0]    st;
    logic          m;
    logic [CW-1:0] cnt;
    logic [3:0]    lz;
  } exp_t;

  exp_t sb[$];
  logic [3:0] hist [4];
  int mcnt;
  logic [3:0] mlz;
  int total = 0;
  int bad = 0;

  z_sequence_detector #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .z_in       (z_in),
    .z_valid    (z_valid),
    .clear      (clear),
    .match      (match),
    .match_count(match_count),
    .last_z     (last_z),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) hist[k] = 4'h0;
    mcnt = 0;
    mlz  = 4'h0;
  endtask

  // Progress = longest tail of the consumed history that is a prefix of 1,2,4,8.
  function automatic logic [1:0] model_state();
    if (hist[0] == 4'h1) return 2'd1;
    if (hist[1] == 4'h1 && hist[0] == 4'h2) return 2'd2;
    if (hist[2] == 4'h1 && hist[1] == 4'h2 && hist[0] == 4'h4) return 2'd3;
    return 2'd0;
  endfunction

  task automatic drive(input logic v, input logic [3:0] z, input logic c);
    exp_t e;
    z_valid = v;
    z_in    = z;
    clear   = c;
    e.m     = 1'b0;
    if (c) begin
      model_clear();
    end else if (v) begin
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = z;
      mlz = z;
      e.m = (hist[3] == 4'h1 && hist[2] == 4'h2 && hist[1] == 4'h4 && hist[0] == 4'h8);
      if (e.m && mcnt < SAT) mcnt++;
    end
    e.st  = model_state();
    e.cnt = CW'(mcnt);
    e.lz  = mlz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    z_valid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; z_valid = 1'b1; z_in = 4'h1; clear = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({state, match, match_count, last_z} !== '0) begin
        bad++;
        $display("FAIL reset cyc %0d: got st=%0d m=%0b cnt=%0d lz=%h want all zero",
                 i, state, match, match_count, last_z);
      end
    end
    z_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] seq [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(i != 0, seq[i], i == 0);
      e = sb.pop_front();
      total++;
      if ({state, match, match_count, last_z} !== e) begin
        bad++;
        $display("FAIL basic step %0d: got st=%0d m=%0b cnt=%0d lz=%h want st=%0d m=%0b cnt=%0d lz=%h",
                 i, state, match, match_count, last_z, e.st, e.m, e.cnt, e.lz);
      end
    end
  endtask

  task automatic test_gaps();
    logic [3:0] seq [9] = '{4'h0, 4'h1, 4'h8, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h8};
    int pulses = 0;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      drive(i != 0 && i != 2, seq[i], i == 0);
      e = sb.pop_front();
      pulses += int'(match);
      total++;
      if ({state, match, match_count, last_z} !== e) begin
        bad++;
        $display("FAIL gaps step %0d: got st=%0d m=%0b cnt=%0d lz=%h want st=%0d m=%0b cnt=%0d lz=%h",
                 i, state, match, match_count, last_z, e.st, e.m, e.cnt, e.lz);
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL gaps pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    exp_t e;
    drive(1'b0, 4'h0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'(1 << (i % 4)), 1'b0);
      e = sb.pop_front();
      pulses += int'(match);
      total++;
      if ({state, match, match_count, last_z} !== e) begin
        bad++;
        $display("FAIL b2b step %0d: got st=%0d m=%0b cnt=%0d lz=%h want st=%0d m=%0b cnt=%0d lz=%h",
                 i, state, match, match_count, last_z, e.st, e.m, e.cnt, e.lz);
      end
      if (i == 7) begin
        total++;
        if (pulses != 2 || match_count !== CW'(2)) begin
          bad++;
          $display("FAIL b2b two: got pulses=%0d cnt=%0d want 2 and 2", pulses, match_count);
        end
      end
    end
    total++;
    if (pulses != 5 || match_count !== CW'(SAT)) begin
      bad++;
      $display("FAIL saturate: got pulses=%0d cnt=%0d want 5 and %0d", pulses, match_count, SAT);
    end
  endtask

  task automatic test_clear_collision();
    logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], i == 3);
      e = sb.pop_front();
      total++;
      if ({state, match, match_count, last_z} !== e) begin
        bad++;
        $display("FAIL clear step %0d: got st=%0d m=%0b cnt=%0d lz=%h want st=%0d m=%0b cnt=%0d lz=%h",
                 i, state, match, match_count, last_z, e.st, e.m, e.cnt, e.lz);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    exp_t e;
    drive(1'b1, 4'h8, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        #2 reset = 1'b0;
        #1;
        model_clear();
        total++;
        if ({state, match, match_count, last_z} !== '0) begin
          bad++;
          $display("FAIL async immediate: got st=%0d m=%0b cnt=%0d lz=%h want all zero",
                   state, match, match_count, last_z);
        end
        reset = 1'b1;
      end
      drive(1'b1, seq[i], 1'b0);
      e = sb.pop_front();
      total++;
      if ({state, match, match_count, last_z} !== e) begin
        bad++;
        $display("FAIL async step %0d: got st=%0d m=%0b cnt=%0d lz=%h want st=%0d m=%0b cnt=%0d lz=%h",
                 i, state, match, match_count, last_z, e.st, e.m, e.cnt, e.lz);
      end
    end
  endtask

  initial begin
    z_in = 4'h0; z_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clear_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z_sequence_detector.md
Z_SEQUENCE_DETECTOR -- requirements
Module: z_sequence_detector

Interface
REQ-001 Parameter COUNT_W, default 8, SHALL set the width of the match counter.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port z_in  input  4  SHALL carry the 4-bit Z result produced by the upstream source stage.
REQ-005 Port z_valid  input  1  SHALL qualify z_in; a sample is consumed only at an edge where z_valid=1.
REQ-006 Port clear  input  1  SHALL be a synchronous clear of counter and FSM.
REQ-007 Port match  output  1  SHALL pulse high for one cycle when the pattern completes.
REQ-008 Port match_count  output  COUNT_W  SHALL hold the saturating number of completed patterns.
REQ-009 Port last_z  output  4  SHALL hold the most recently consumed z_in sample.
REQ-010 Port state  output  2  SHALL expose the current FSM state encoding.

Function
REQ-011 The block SHALL detect the consumed-sample sequence 4'h1, 4'h2, 4'h4, 4'h8 (one-hot walk).
REQ-012 FSM states SHALL be IDLE=0, GOT1=1, GOT2=2, GOT4=3.
REQ-013 IDLE: sample 4'h1 -> GOT1; any other -> IDLE.
REQ-014 GOT1: 4'h2 -> GOT2; 4'h1 -> GOT1; other -> IDLE.
REQ-015 GOT2: 4'h4 -> GOT4; 4'h1 -> GOT1; other -> IDLE.
REQ-016 GOT4: 4'h8 -> IDLE with match event; 4'h1 -> GOT1; other -> IDLE.
REQ-017 At edges with z_valid=0, state, last_z, match_count SHALL hold, and match SHALL be 0.
REQ-018 match SHALL be registered: high exactly during the cycle after the edge consuming the completing 4'h8.
REQ-019 match_count SHALL increment at that same edge, so count and match are visible together.
REQ-020 match_count SHALL saturate at 2**COUNT_W-1; further matches still pulse match but do not wrap.
REQ-021 last_z SHALL load z_in at every edge with z_valid=1 and clear=0.
REQ-022 clear=1 at an edge SHALL force state=IDLE, match_count=0, match=0, last_z=0; a valid sample at that edge SHALL be discarded (clear wins).
REQ-023 Back-to-back patterns with no idle cycles SHALL each be detected (8 cycles -> 2 matches).
REQ-024 Latency from completing sample to match SHALL be exactly one clock.

Reset
REQ-025 reset=0 SHALL immediately, without a clock, force state=IDLE, match=0, match_count=0, last_z=0.
REQ-026 Reset asserted mid-pattern SHALL discard partial progress; after release, detection restarts from IDLE.
REQ-027 Release of reset SHALL take effect at the first rising clk edge with reset=1.

Structure
REQ-028 A shared package z_pkg SHALL hold the state encodings and the four pattern constants (4'h1, 4'h2, 4'h4, 4'h8).
REQ-029 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, reset, inc, clr; output count).
REQ-030 FSM next-state logic SHALL be combinational; all outputs SHALL come straight from flops.

Verification
REQ-031 Reset: hold reset=0, drive z_valid=1, z_in=4'h1 for 3 clocks -> state=0, match=0, match_count=0, last_z=0 throughout.
REQ-032 Basic: z_in 1,2,4,8 with z_valid=1 on 4 consecutive edges -> match=1 for one cycle after the 4th edge, match_count=1, state=0.
REQ-033 Gaps and restart: 1,(valid=0),2,4,1,2,4,8 -> exactly one match after last sample; count=1; state holds during the gap.
REQ-034 Saturation (COUNT_W=2): 5 back-to-back patterns -> match pulses 5 times, match_count ends at 3.
REQ-035 Clear collision: 1,2,4 then clear=1 with z_in=8, z_valid=1 -> no match, count=0, state=0, last_z=0.
REQ-036 Async reset mid-pattern: 1,2 then pulse reset=0 between edges -> outputs zero immediately; subsequent 4,8 produce no match.
